// File: rtl/mem_map_pkg.sv
// Address map and state encodings shared by the memory responder and its bench.
// The I/O registers sit at fixed addresses at the top of the 8-bit map.
package mem_map_pkg;

  localparam logic [7:0] IO_BASE     = 8'hF0;
  localparam logic [7:0] ADDR_LED    = 8'hF0;
  localparam logic [7:0] ADDR_SW     = 8'hF1;
  localparam logic [7:0] ADDR_TIMER  = 8'hF2;
  localparam logic [7:0] ADDR_STATUS = 8'hF3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_RAM    = 3'd0,
    SEL_LED    = 3'd1,
    SEL_SW     = 3'd2,
    SEL_TIMER  = 3'd3,
    SEL_STATUS = 3'd4,
    SEL_NONE   = 3'd5
  } sel_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the processor's control unit/datapath and the
// memory responder.
interface mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              MemWait;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemWait
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemWait
  );
endinterface

// File: rtl/mem_ram.sv
// Single-port synchronous RAM with a registered read (read-first on a write).
// Contents are deliberately not reset.
module mem_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 240
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: wait-state FSM, RAM/I-O address decode, LED, switch,
// timer and status registers for the multicycle processor.
module mem_responder #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(mem_map_pkg::IO_BASE),
  parameter int                WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_responder_if.slave        bus,
  input  logic [7:0]            SW,
  output logic [7:0]            LEDR,
  output logic                  ProtoErr
);
  import mem_map_pkg::*;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            r_state, w_state_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic [7:0]        r_led;
  logic [7:0]        r_timer;
  logic [7:0]        r_sw_meta, r_sw_sync;
  logic              r_proto_err;
  logic [DATA_W-1:0] r_rd_io;
  logic              r_rd_is_ram;

  logic              w_req, w_start, w_commit, w_enter_ack;
  logic [ADDR_W-1:0] w_acc_addr;
  sel_t              w_sel;
  logic [DATA_W-1:0] w_io_rdata;
  logic [DATA_W-1:0] w_ram_q;

  assign w_req       = bus.MemRead | bus.MemWrite;
  assign w_start     = (r_state == ST_IDLE) & w_req;
  assign w_commit    = (r_state == ST_ACK) & r_is_write;
  assign w_enter_ack = (w_state_next == ST_ACK);
  // Live address in IDLE lets a zero-wait access read the RAM on its first edge.
  assign w_acc_addr  = (r_state == ST_IDLE) ? bus.Addr : r_addr;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = ST_ACK;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_next = ST_ACK;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel = SEL_NONE;
    if (w_acc_addr < IO_BASE) begin
      w_sel = SEL_RAM;
    end else begin
      case (w_acc_addr)
        ADDR_W'(ADDR_LED):    w_sel = SEL_LED;
        ADDR_W'(ADDR_SW):     w_sel = SEL_SW;
        ADDR_W'(ADDR_TIMER):  w_sel = SEL_TIMER;
        ADDR_W'(ADDR_STATUS): w_sel = SEL_STATUS;
        default:              w_sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    w_io_rdata = '0;
    case (w_sel)
      SEL_LED:    w_io_rdata = DATA_W'(r_led);
      SEL_SW:     w_io_rdata = DATA_W'(r_sw_sync);
      SEL_TIMER:  w_io_rdata = DATA_W'(r_timer);
      SEL_STATUS: w_io_rdata = DATA_W'({7'd0, r_proto_err});
      default:    w_io_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_rd_io     <= '0;
      r_rd_is_ram <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_start) begin
        r_addr     <= bus.Addr;
        r_wdata    <= bus.WriteData;
        r_is_write <= bus.MemWrite;
      end
      if (w_enter_ack) begin
        r_rd_io     <= w_io_rdata;
        r_rd_is_ram <= (w_sel == SEL_RAM);
      end
    end
  end

  // A clear written to the status register loses to a simultaneous protocol error.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_led       <= 8'h00;
      r_timer     <= 8'h00;
      r_sw_meta   <= 8'h00;
      r_sw_sync   <= 8'h00;
      r_proto_err <= 1'b0;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
      if (w_commit && w_sel == SEL_TIMER) begin
        r_timer <= 8'h00;
      end else begin
        r_timer <= r_timer + 8'd1;
      end
      if (w_commit && w_sel == SEL_LED) begin
        r_led <= 8'(r_wdata);
      end
      if (w_start && bus.MemRead && bus.MemWrite) begin
        r_proto_err <= 1'b1;
      end else if (w_commit && w_sel == SEL_STATUS && r_wdata[0]) begin
        r_proto_err <= 1'b0;
      end
    end
  end

  mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (int'(IO_BASE))
  ) u_ram (
    .clock   (clock),
    .i_we    (w_commit && (w_sel == SEL_RAM) && !reset),
    .i_addr  (w_acc_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  assign bus.ReadData = (r_state == ST_ACK) ? (r_rd_is_ram ? w_ram_q : r_rd_io) : '0;
  assign bus.MemWait  = w_req & (r_state != ST_ACK);
  assign LEDR         = r_led;
  assign ProtoErr     = r_proto_err;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle processor's memory interface. It services the control unit's MemRead/MemWrite requests with a configurable number of wait states and reports completion through MemWait. It decodes the address into on-chip RAM and a small memory-mapped I/O region: LEDs, switches, a free-running timer and a status register. It sits between the datapath's address/data buses and the DE2 board I/O.

## Interface
- DATA_W, 8, data bus width
- ADDR_W, 8, address bus width
- IO_BASE, 8'hF0, first I/O address; RAM occupies 0 .. IO_BASE-1
- WAIT_CYCLES, 1, wait states per access, legal range 0..15
- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- MemRead  in  1  read request, level, held by the requester until completion
- MemWrite  in  1  write request, level, held by the requester until completion
- Addr  in  ADDR_W  request address, stable while the request is held
- WriteData  in  DATA_W  write data, stable while MemWrite is held
- ReadData  out  DATA_W  read result, valid only in ACK
- MemWait  out  1  high while a request is outstanding and not yet acknowledged
- SW  in  8  board switches, asynchronous
- LEDR  out  8  LED register
- ProtoErr  out  1  sticky flag, set by a request with both MemRead and MemWrite high

## Operation
- States and transitions:
  - IDLE: when MemRead or MemWrite is high, latch Addr, WriteData and the operation. Go to ACK if WAIT_CYCLES==0, otherwise go to WAIT with cnt=WAIT_CYCLES-1.
  - WAIT: if the request is dropped, abort to IDLE with no side effects. If cnt==0, go to ACK; otherwise cnt-1.
  - ACK: unconditionally return to IDLE. The write commits on this exiting edge. Read data is presented during ACK.
- MemWait = (MemRead|MemWrite) & (state!=ACK). The combinational path runs from the request inputs to MemWait only.
- Both request lines high:
  - The access is treated as a write.
  - ProtoErr is set at the IDLE-exit edge.
- Address decode uses the latched address:
  - Below IO_BASE: RAM read or write.
  - 0xF0 LEDR: read/write.
  - 0xF1 SW: read-only, through a 2-flop synchronizer; writes are ignored.
  - 0xF2 timer: read-only, an 8-bit free-running counter that wraps at 0xFF→0x00. A write clears it to 0 on the commit edge, overriding the increment.
  - 0xF3 status: bit0=ProtoErr, other bits read 0. Writing with bit0=1 clears ProtoErr. A set and a clear on the same edge: the set wins.
  - 0xF4–0xFF: read 0x00, writes ignored.
- ReadData is registered on entry to ACK and is 0x00 in all other states.
- RAM contents are not cleared by reset.
- Back-to-back requests: a request still high in the IDLE cycle after ACK is a new access.

## Timing
- Reset values: state=IDLE, cnt=0, ReadData=0x00, LEDR=0x00, ProtoErr=0, timer=0x00, synchronizer=0x00. MemWait follows its equation, so it is 1 if a request is held during reset.
- Reset mid-operation: return to IDLE, no write commits, ReadData=0.
- Access latency from the first request cycle (in IDLE) to the ACK cycle: WAIT_CYCLES+1 cycles. Total occupancy is WAIT_CYCLES+2 cycles including ACK.
- Timer increments every cycle outside reset.
- SW reaches a read with a latency of 2 cycles of synchronization.
- Register widths:
  - cnt is 4 bits.
  - Addr is compared at full ADDR_W width.
  - RAM depth is IO_BASE words.

## Structure
- Shared package mem_map_pkg holds:
  - the address constants ADDR_LED=8'hF0, ADDR_SW=8'hF1, ADDR_TIMER=8'hF2, ADDR_STATUS=8'hF3, IO_BASE;
  - the state encoding IDLE/WAIT/ACK as 2-bit constants.
- One sub-module, mem_ram: single-port synchronous RAM with DEPTH=IO_BASE and width DATA_W.
  - Registered read, write-enable input.
  - Read data is registered so that it is available in ACK. For WAIT_CYCLES==0, read from IDLE using the live Addr.

## Test plan
- WAIT_CYCLES=1: write 0x5A to 0x10, then read 0x10 → MemWait high for 2 cycles per access, ReadData=0x5A in ACK, 3-cycle occupancy each.
- WAIT_CYCLES=0: back-to-back reads at 0x00 and 0x01, previously written 0x11 and 0x22 → ACK on the cycle after each IDLE, ReadData=0x11 then 0x22.
- Write 0xC3 to 0xF0 → LEDR=0xC3 after the commit edge. Set SW=0x81, wait 3 cycles, read 0xF1 → ReadData=0x81. Write 0x00 to 0xF1 → SW read unchanged.
- Write to 0xF2, then read 0xF2 → value equals the cycles elapsed since commit, modulo 256. Let the timer run 256 cycles → wraps to the same value.
- Request with both MemRead and MemWrite high at 0x20 with data 0x77 → treated as write, ProtoErr=1, read of 0x20 gives 0x77. Write 0x01 to 0xF3 → ProtoErr=0.
- WAIT_CYCLES=3: drop MemWrite in WAIT, then assert reset during a later WAIT → no RAM change at the target address, state returns to IDLE, ReadData=0x00.
